// File: rtl/midi_voice_alloc.sv
// Note-to-voice allocator for the 8-channel interrupter tone generator bank.
// Optional oldest-voice stealing is enabled by defining VOICE_STEAL_EN.
module midi_voice_alloc #(
    parameter int NUM_VOICES = 8,
    parameter int PERIOD_W   = 32,
    parameter int NOTE_W     = 7
) (
    input  logic                           CLOCK_50,
    input  logic                           RESET,
    input  logic                           evt_valid,
    output logic                           evt_ready,
    input  logic                           evt_on,
    input  logic [NOTE_W-1:0]              evt_note,
    input  logic [PERIOD_W-1:0]            evt_period,
    input  logic                           panic,
    output logic [NUM_VOICES*PERIOD_W-1:0] voice_lim,
    output logic [NUM_VOICES-1:0]          voice_active,
    output logic [NUM_VOICES*NOTE_W-1:0]   voice_note,
    output logic                           alloc_pulse,
    output logic [2:0]                     alloc_idx,
    output logic                           drop_pulse
);

    localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_COMMIT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [PERIOD_W-1:0] r_lim    [NUM_VOICES];
    logic [NOTE_W-1:0]   r_vnote  [NUM_VOICES];
    logic [IW-1:0]       r_age    [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_active;

    logic                r_on;
    logic [NOTE_W-1:0]   r_note;
    logic [PERIOD_W-1:0] r_period;
    logic [IW-1:0]       r_idx;

    logic                r_m_vld;
    logic [IW-1:0]       r_m_idx;
    logic                r_f_vld;
    logic [IW-1:0]       r_f_idx;
`ifdef VOICE_STEAL_EN
    logic [IW-1:0]       r_o_idx;
    logic [IW-1:0]       r_o_age;
`endif

    logic                r_alloc_pulse;
    logic [2:0]          r_alloc_idx;
    logic                r_drop_pulse;

    logic                w_accept;
    logic                w_cur_act;
    logic [NOTE_W-1:0]   w_cur_note;
    logic [IW-1:0]       w_cur_age;
    logic                w_on_eff;
    logic                w_wr_en;
    logic                w_new;
    logic                w_clr;
    logic                w_drop;
    logic [IW-1:0]       w_wr_idx;

    // Flatten per-voice registers onto the packed output buses
    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_out
        assign voice_lim[v*PERIOD_W +: PERIOD_W] = r_lim[v];
        assign voice_note[v*NOTE_W +: NOTE_W]    = r_vnote[v];
    end

    assign voice_active = r_active;
    assign alloc_pulse  = r_alloc_pulse;
    assign alloc_idx    = r_alloc_idx;
    assign drop_pulse   = r_drop_pulse;

    assign w_accept   = evt_valid & evt_ready;
    assign w_cur_act  = r_active[r_idx];
    assign w_cur_note = r_vnote[r_idx];
    assign w_cur_age  = r_age[r_idx];
    assign w_on_eff   = r_on & (r_period != '0);

    // FSM state register; panic forces IDLE
    always_ff @(posedge CLOCK_50) begin
        if (RESET || panic) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_SCAN;
            S_SCAN:   if (r_idx == LAST) w_next = S_COMMIT;
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // FSM outputs: accept only when idle and not panicking
    always_comb begin
        evt_ready = (r_state == S_IDLE) & ~panic;
    end

    // Commit decision from the scan trackers
    always_comb begin
        w_wr_en  = 1'b0;
        w_new    = 1'b0;
        w_clr    = 1'b0;
        w_drop   = 1'b0;
        w_wr_idx = '0;
        if (r_state == S_COMMIT) begin
            if (w_on_eff) begin
                if (r_m_vld) begin
                    w_wr_en  = 1'b1;
                    w_wr_idx = r_m_idx;
                end else if (r_f_vld) begin
                    w_wr_en  = 1'b1;
                    w_new    = 1'b1;
                    w_wr_idx = r_f_idx;
                end else begin
`ifdef VOICE_STEAL_EN
                    w_wr_en  = 1'b1;
                    w_new    = 1'b1;
                    w_wr_idx = r_o_idx;
`else
                    w_drop   = 1'b1;
`endif
                end
            end else if (r_m_vld) begin
                w_clr    = 1'b1;
                w_wr_idx = r_m_idx;
            end
        end
    end

    // Event latch, scan trackers, voice table and strobes
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_lim[v]   <= '0;
                r_vnote[v] <= '0;
                r_age[v]   <= '0;
            end
            r_active      <= '0;
            r_on          <= 1'b0;
            r_note        <= '0;
            r_period      <= '0;
            r_idx         <= '0;
            r_m_vld       <= 1'b0;
            r_m_idx       <= '0;
            r_f_vld       <= 1'b0;
            r_f_idx       <= '0;
`ifdef VOICE_STEAL_EN
            r_o_idx       <= '0;
            r_o_age       <= '0;
`endif
            r_alloc_pulse <= 1'b0;
            r_alloc_idx   <= '0;
            r_drop_pulse  <= 1'b0;
        end else if (panic) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_lim[v] <= '0;
                r_age[v] <= '0;
            end
            r_active      <= '0;
            r_idx         <= '0;
            r_alloc_pulse <= 1'b0;
            r_drop_pulse  <= 1'b0;
        end else begin
            r_alloc_pulse <= 1'b0;
            r_drop_pulse  <= 1'b0;

            if (r_state == S_IDLE && w_accept) begin
                r_on     <= evt_on;
                r_note   <= evt_note;
                r_period <= evt_period;
                r_idx    <= '0;
                r_m_vld  <= 1'b0;
                r_m_idx  <= '0;
                r_f_vld  <= 1'b0;
                r_f_idx  <= '0;
`ifdef VOICE_STEAL_EN
                r_o_idx  <= '0;
                r_o_age  <= '0;
`endif
            end

            if (r_state == S_SCAN) begin
                if (!r_m_vld && w_cur_act && w_cur_note == r_note) begin
                    r_m_vld <= 1'b1;
                    r_m_idx <= r_idx;
                end
                if (!r_f_vld && !w_cur_act) begin
                    r_f_vld <= 1'b1;
                    r_f_idx <= r_idx;
                end
`ifdef VOICE_STEAL_EN
                if (w_cur_age > r_o_age) begin
                    r_o_age <= w_cur_age;
                    r_o_idx <= r_idx;
                end
`endif
                r_idx <= IW'(r_idx + 1'b1);
            end

            if (w_wr_en) begin
                r_lim[w_wr_idx] <= r_period;
                r_alloc_pulse   <= 1'b1;
                r_alloc_idx     <= 3'(w_wr_idx);
                if (w_new) begin
                    r_active[w_wr_idx] <= 1'b1;
                    r_vnote[w_wr_idx]  <= r_note;
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (IW'(v) == w_wr_idx) begin
                            r_age[v] <= '0;
                        end else if (r_active[v] && r_age[v] != LAST) begin
                            r_age[v] <= IW'(r_age[v] + 1'b1);
                        end
                    end
                end
            end

            if (w_clr) begin
                r_active[w_wr_idx] <= 1'b0;
                r_lim[w_wr_idx]    <= '0;
                r_age[w_wr_idx]    <= '0;
            end

            if (w_drop) begin
                r_drop_pulse <= 1'b1;
            end
        end
    end

endmodule

// File: doc/midi_voice_alloc.md
Name: midi_voice_alloc

Overview:
- Voice allocator/scheduler for the 8-channel tone generator bank of the DRSSTC MIDI interrupter.
- Accepts note-on/note-off events from the MCU-side bus decoder and assigns each note to a generator channel.
- Drives each channel's period limit; a zero limit silences that channel.
- Sits between the event decoder and the generator/on-off-time-protect datapath, replacing direct host writes of per-generator limits.

Parameters:
NUM_VOICES, 8, number of generator channels managed
PERIOD_W, 32, width of period limit in CLOCK_50 cycles
NOTE_W, 7, MIDI note number width

Ports:
CLOCK_50  input  1  system clock, 50 MHz
RESET  input  1  synchronous, active-high reset
evt_valid  input  1  event present
evt_ready  output  1  allocator can accept event
evt_on  input  1  1 = note-on, 0 = note-off
evt_note  input  NOTE_W  MIDI note number
evt_period  input  PERIOD_W  generator limit for note-on
panic  input  1  all-notes-off, level-sensitive
voice_lim  output  NUM_VOICES*PERIOD_W  per-voice limit, voice v at [v*PERIOD_W +: PERIOD_W]
voice_active  output  NUM_VOICES  voice holds a note
voice_note  output  NUM_VOICES*NOTE_W  note held per voice
alloc_pulse  output  1  one-cycle strobe when a voice is written
alloc_idx  output  3  voice written, valid with alloc_pulse
drop_pulse  output  1  one-cycle strobe when a note-on is discarded

Behaviour:
- Reset: all voice_lim = 0, voice_active = 0, voice_note = 0, ages = 0, alloc_pulse = 0, drop_pulse = 0, alloc_idx = 0, FSM = IDLE, evt_ready = 1 on the first cycle after reset.
- FSM states: IDLE, SCAN, COMMIT.
- IDLE:
  - evt_ready = ~panic.
  - evt_valid & evt_ready latches evt_on, evt_note and evt_period, clears the scan trackers and moves to SCAN with index 0.
- SCAN: one voice per cycle, index 0..NUM_VOICES-1. Three trackers:
  - match: first active voice whose note equals evt_note.
  - free: lowest-index inactive voice.
  - oldest: voice with maximum age; lowest index wins ties.
  - After the last index, go to COMMIT.
- COMMIT (one cycle), then IDLE:
  - A note-on with evt_period == 0 is treated as a note-off.
  - Note-on with match: retrigger. Set lim = period on the matched voice. No age change. alloc_pulse.
  - Note-on without match, free voice exists: write that voice (active = 1, note, lim). Its age becomes 0; every other active voice's age increments, saturating at NUM_VOICES-1. alloc_pulse.
  - Note-on without match or free voice: steal the oldest voice and write it as for a free voice. alloc_pulse. See Optional Feature.
  - Note-off with match: active = 0, lim = 0, age = 0. No pulse.
  - Note-off without match: no state change, no pulse.
- Timing:
  - Accept at cycle T; SCAN occupies T+1..T+NUM_VOICES; COMMIT at T+NUM_VOICES+1.
  - Outputs and pulses are visible at T+NUM_VOICES+2, when evt_ready returns high.
  - Throughput: one event per NUM_VOICES+2 cycles.
- Panic in any state, each cycle it is high:
  - All voice_lim, voice_active and ages are cleared.
  - Any in-flight event is discarded with no pulses.
  - FSM forced to IDLE.
  - Panic wins over a simultaneous evt_valid (evt_ready is 0).
- RESET mid-scan: same result as panic, plus all registers return to their reset values.
- Only one voice may hold a given note; the match path guarantees this.
- voice_lim changes only in COMMIT, panic or reset.
- A generator period may be restarted mid-cycle by a retrigger; this is acceptable.

Optional Feature:
- Macro VOICE_STEAL_EN.
- Defined: a note-on with no match and no free voice steals the oldest voice as described, with no drop_pulse.
- Undefined:
  - The same case leaves all voices unchanged and asserts drop_pulse for one cycle at T+NUM_VOICES+2.
  - No alloc_pulse. Ages are unchanged.
  - The oldest tracker logic is not synthesized.

Test Plan:
- Reset, then note-on note=60 period=95556 -> at T+10: voice 0 lim=95556, active=0x01, alloc_pulse with alloc_idx=0, evt_ready low T+1..T+9.
- Note-on 60, 64, 67, then note-off 64 -> voice1 lim=0, active=0x05; next note-on 72 period=47778 -> voice 1, active=0x07.
- Note-on 60 period=95556, then note-on 60 period=90192 -> still voice 0 only, lim=90192, active=0x01.
- Nine distinct note-ons 60..68 with 8 voices:
  - With VOICE_STEAL_EN: note 68 lands in voice 0 (oldest), voice_note[0]=68.
  - Without VOICE_STEAL_EN: drop_pulse and voices unchanged.
- Four voices active, raise panic during SCAN of a fifth note-on -> next cycle all lim=0, active=0, no alloc_pulse; evt_ready=1 the cycle after panic falls.
- Note-off for note 50 never held, and note-on period=0 for an unheld note -> no output change, no alloc_pulse, no drop_pulse.
